id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage for the 5-stage RV32 core. Registers decoded operands and control at the ID/EX boundary, resolves RAW hazards by forwarding from MEM and WB, and inserts load-use bubbles. Drives `alu_op1`, `alu_op2` and `alu_ctrl` straight into `alu`, plus the control and store data the EX/MEM register consumes.

---
 rtl/id_ex_if.sv | 63 ++++++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID fields, MEM/WB producer info and the EX-side outputs.
// The stage uses the slave modport; whoever drives ID and the producers uses master.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc;
    logic [2:0]        id_alu_ctrl;
    logic              id_alusrc;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic              id_branch;
    logic              flush;

    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [DATA_W-1:0] mem_result;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic [DATA_W-1:0] wb_result;

    logic              stall;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [2:0]        alu_ctrl;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_branch;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_store_data;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd1, id_rd2, id_imm, id_pc,
        input  id_alu_ctrl, id_alusrc, id_rd,
        input  id_regwrite, id_memread, id_memwrite, id_branch, flush,
        input  mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
        output stall, alu_op1, alu_op2, alu_ctrl,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
        output ex_rd, ex_pc, ex_imm, ex_store_data
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd1, id_rd2, id_imm, id_pc,
        output id_alu_ctrl, id_alusrc, id_rd,
        output id_regwrite, id_memread, id_memwrite, id_branch, flush,
        output mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
        input  stall, alu_op1, alu_op2, alu_ctrl,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
        input  ex_rd, ex_pc, ex_imm, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB capture bypass, MEM/WB forwarding and bubble insertion; ID->EX latency 1 cycle.
// Backpressure: stall holds PC and IF/ID. ID_EX_FORWARDING_EN enables EX-side forwarding, else stall until the producer reaches WB.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic      clk,
    input  logic      rst,
    id_ex_if.slave    io_if
);
    logic              r_valid;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [2:0]        r_alu_ctrl;
    logic              r_alusrc;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_branch;

    logic              w_cap1;
    logic              w_cap2;
    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;
    logic              w_hazard;
    logic              w_stall;

    // Register file writes and reads in the same cycle; capture the value being written.
    always_comb begin
        w_cap1 = io_if.wb_regwrite && (io_if.wb_rd != '0) && (io_if.wb_rd == io_if.id_rs1);
        w_cap2 = io_if.wb_regwrite && (io_if.wb_rd != '0) && (io_if.wb_rd == io_if.id_rs2);
    end

`ifdef ID_EX_FORWARDING_EN
    always_comb begin
        w_fwd1 = r_rd1;
        if (io_if.mem_regwrite && (io_if.mem_rd != '0) && (io_if.mem_rd == r_rs1))
            w_fwd1 = io_if.mem_result;
        else if (io_if.wb_regwrite && (io_if.wb_rd != '0) && (io_if.wb_rd == r_rs1))
            w_fwd1 = io_if.wb_result;

        w_fwd2 = r_rd2;
        if (io_if.mem_regwrite && (io_if.mem_rd != '0) && (io_if.mem_rd == r_rs2))
            w_fwd2 = io_if.mem_result;
        else if (io_if.wb_regwrite && (io_if.wb_rd != '0) && (io_if.wb_rd == r_rs2))
            w_fwd2 = io_if.wb_result;
    end

    // Only a load in EX cannot be forwarded in time: one bubble lets it reach MEM.
    always_comb begin
        w_hazard = io_if.id_valid && r_valid && r_memread && (r_rd != '0) &&
                   ((r_rd == io_if.id_rs1) || (r_rd == io_if.id_rs2));
    end
`else
    always_comb begin
        w_fwd1 = r_rd1;
        w_fwd2 = r_rd2;
    end

    // Without forwarding, wait until every in-flight producer reaches WB and is captured.
    always_comb begin
        w_hazard = 1'b0;
        if (io_if.id_valid) begin
            if ((io_if.id_rs1 != '0) &&
                ((r_valid && r_regwrite && (r_rd == io_if.id_rs1)) ||
                 (io_if.mem_regwrite && (io_if.mem_rd == io_if.id_rs1))))
                w_hazard = 1'b1;
            if ((io_if.id_rs2 != '0) &&
                ((r_valid && r_regwrite && (r_rd == io_if.id_rs2)) ||
                 (io_if.mem_regwrite && (io_if.mem_rd == io_if.id_rs2))))
                w_hazard = 1'b1;
        end
    end
`endif

    // Flush overrides the bubble, and reset forces the stall request low.
    always_comb begin
        w_stall = w_hazard && !io_if.flush && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_alu_ctrl <= 3'b000;
            r_alusrc   <= 1'b0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
        end else if (io_if.flush || w_stall) begin
            // Bubble: data fields keep stale values, nothing downstream acts on them.
            r_valid    <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
        end else begin
            r_valid    <= io_if.id_valid;
            r_rs1      <= io_if.id_rs1;
            r_rs2      <= io_if.id_rs2;
            r_rd1      <= w_cap1 ? io_if.wb_result : io_if.id_rd1;
            r_rd2      <= w_cap2 ? io_if.wb_result : io_if.id_rd2;
            r_imm      <= io_if.id_imm;
            r_pc       <= io_if.id_pc;
            r_alu_ctrl <= io_if.id_alu_ctrl;
            r_alusrc   <= io_if.id_alusrc;
            r_rd       <= io_if.id_rd;
            r_regwrite <= io_if.id_regwrite;
            r_memread  <= io_if.id_memread;
            r_memwrite <= io_if.id_memwrite;
            r_branch   <= io_if.id_branch;
        end
    end

    always_comb begin
        io_if.stall         = w_stall;
        io_if.alu_op1       = w_fwd1;
        io_if.alu_op2       = r_alusrc ? r_imm : w_fwd2;
        io_if.alu_ctrl      = r_alu_ctrl;
        io_if.ex_valid      = r_valid;
        io_if.ex_regwrite   = r_regwrite;
        io_if.ex_memread    = r_memread;
        io_if.ex_memwrite   = r_memwrite;
        io_if.ex_branch     = r_branch;
        io_if.ex_rd         = r_rd;
        io_if.ex_pc         = r_pc;
        io_if.ex_imm        = r_imm;
        io_if.ex_store_data = w_fwd2;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow whether ID_EX_FORWARDING_EN is defined.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_if (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd1 = 0; bus.id_rd2 = 0;
        bus.id_imm = 0; bus.id_pc = 0; bus.id_alu_ctrl = 0; bus.id_alusrc = 0; bus.id_rd = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_branch = 0;
        bus.flush = 0;
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_result = 0;
        bus.wb_rd = 0; bus.wb_regwrite = 0; bus.wb_result = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs1, input logic [31:0] rd1,
                            input logic [4:0] rs2, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [2:0] ctrl, input logic alusrc, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw, input logic br);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rd1 = rd1; bus.id_rs2 = rs2; bus.id_rd2 = rd2;
        bus.id_imm = imm; bus.id_pc = pc; bus.id_alu_ctrl = ctrl; bus.id_alusrc = alusrc;
        bus.id_rd = rd; bus.id_regwrite = rw; bus.id_memread = mr;
        bus.id_memwrite = mw; bus.id_branch = br;
    endtask

    initial begin
        idle_all();
        rst = 1;
        #12;
        rst = 0;

        // lw x7, 4(x2) into EX; then an add reading x7 in ID.
        drive_id(5'd2, 32'h300, 5'd0, 32'h55, 32'h4, 32'h40, 3'b010, 1, 5'd7, 1, 1, 0, 0);
        tick();
        chk("lw_valid", 32'(bus.ex_valid), 32'd1);
        chk("lw_memread", 32'(bus.ex_memread), 32'd1);
        chk("lw_rd", 32'(bus.ex_rd), 32'd7);
        chk("lw_op1", bus.alu_op1, 32'h300);
        chk("lw_op2_imm", bus.alu_op2, 32'h4);
        chk("lw_store", bus.ex_store_data, 32'h55);
        drive_id(5'd1, 32'h11, 5'd7, 32'hBAD, 32'h0, 32'h44, 3'b000, 0, 5'd8, 1, 0, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #1 rst = 1;
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("rst_memread", 32'(bus.ex_memread), 32'd0);
        chk("rst_memwrite", 32'(bus.ex_memwrite), 32'd0);
        chk("rst_branch", 32'(bus.ex_branch), 32'd0);
        chk("rst_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_op1", bus.alu_op1, 32'd0);
        chk("rst_op2", bus.alu_op2, 32'd0);
        chk("rst_store", bus.ex_store_data, 32'd0);
        chk("rst_pc", bus.ex_pc, 32'd0);
        chk("rst_imm", bus.ex_imm, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);

        // First edge after release loads what ID presents.
        idle_all();
        #3;
        drive_id(5'd1, 32'h100, 5'd0, 32'h0, 32'h20, 32'h80, 3'b011, 1, 5'd4, 1, 0, 0, 1);
        rst = 0;
        tick();
        chk("ld_op1", bus.alu_op1, 32'h100);
        chk("ld_op2", bus.alu_op2, 32'h20);
        chk("ld_ctrl", 32'(bus.alu_ctrl), 32'd3);
        chk("ld_rd", 32'(bus.ex_rd), 32'd4);
        chk("ld_pc", bus.ex_pc, 32'h80);
        chk("ld_branch", 32'(bus.ex_branch), 32'd1);
        chk("ld_valid", 32'(bus.ex_valid), 32'd1);

        // WB capture bypass on rs1.
        drive_id(5'd9, 32'hAAAA, 5'd0, 32'h0, 32'h0, 32'h84, 3'b000, 0, 5'd10, 0, 0, 0, 0);
        bus.wb_rd = 5'd9; bus.wb_regwrite = 1; bus.wb_result = 32'h1234;
        tick();
        bus.wb_regwrite = 0;
        #1;
        chk("wbcap_op1", bus.alu_op1, 32'h1234);
        chk("wbcap_op2", bus.alu_op2, 32'h0);

        // x0 is never captured or forwarded.
        drive_id(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h88, 3'b000, 0, 5'd0, 0, 0, 0, 0);
        bus.wb_rd = 5'd0; bus.wb_regwrite = 1; bus.wb_result = 32'h5555;
        tick();
        bus.mem_rd = 5'd0; bus.mem_regwrite = 1; bus.mem_result = 32'hFFFF;
        #1;
        chk("x0_op1", bus.alu_op1, 32'h0);
        chk("x0_store", bus.ex_store_data, 32'h0);
        idle_all();

        // sub x11, x5, x6 in EX with stored rd1=0xDEAD, rd2=0x77.
        drive_id(5'd5, 32'hDEAD, 5'd6, 32'h77, 32'h0, 32'h8C, 3'b001, 0, 5'd11, 1, 0, 0, 0);
        tick();
        bus.id_valid = 0;
        bus.mem_rd = 5'd5; bus.mem_regwrite = 1; bus.mem_result = 32'h10;
        #1;
        chk("fwd_mem_op1", bus.alu_op1, FWD ? 32'h10 : 32'hDEAD);
        chk("noid_stall", 32'(bus.stall), 32'd0);
        bus.wb_rd = 5'd5; bus.wb_regwrite = 1; bus.wb_result = 32'h20;
        #1;
        chk("fwd_mem_over_wb", bus.alu_op1, FWD ? 32'h10 : 32'hDEAD);
        bus.mem_regwrite = 0;
        #1;
        chk("fwd_wb_op1", bus.alu_op1, FWD ? 32'h20 : 32'hDEAD);
        bus.wb_rd = 5'd6;
        #1;
        chk("fwd_wb_op2", bus.alu_op2, FWD ? 32'h20 : 32'h77);
        chk("fwd_wb_store", bus.ex_store_data, FWD ? 32'h20 : 32'h77);
        bus.wb_regwrite = 0;
        #1;
        chk("nofwd_op1", bus.alu_op1, 32'hDEAD);

        // ALU producer in EX: only the non-forwarding build stalls.
        drive_id(5'd11, 32'h0, 5'd0, 32'h0, 32'h0, 32'h90, 3'b000, 0, 5'd12, 1, 0, 0, 0);
        #1;
        chk("alu_dep_stall", 32'(bus.stall), FWD ? 32'd1 - 32'd1 : 32'd1);

        // Flush wins over a load-use stall.
        drive_id(5'd2, 32'h300, 5'd0, 32'h55, 32'h4, 32'h40, 3'b010, 1, 5'd7, 1, 1, 0, 0);
        tick();
        drive_id(5'd1, 32'h11, 5'd7, 32'hBAD, 32'h0, 32'h44, 3'b000, 0, 5'd8, 1, 0, 0, 0);
        bus.id_valid = 0;
        #1;
        chk("invalid_id_stall", 32'(bus.stall), 32'd0);
        bus.id_valid = 1;
        bus.flush = 1;
        #1;
        chk("flush_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush = 0;
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("flush_rd", 32'(bus.ex_rd), 32'd0);

        // Load-use: lw x7 in EX, add x8, x1, x7 in ID.
        drive_id(5'd2, 32'h300, 5'd0, 32'h55, 32'h4, 32'h40, 3'b010, 1, 5'd7, 1, 1, 0, 0);
        tick();
        drive_id(5'd1, 32'h11, 5'd7, 32'hBAD, 32'h0, 32'h44, 3'b000, 0, 5'd8, 1, 0, 0, 0);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_memread", 32'(bus.ex_memread), 32'd0);
        chk("lu_bubble_rd", 32'(bus.ex_rd), 32'd0);
        bus.mem_rd = 5'd7; bus.mem_regwrite = 1; bus.mem_result = 32'h304;
        #1;
        chk("lu_stall_c2", 32'(bus.stall), FWD ? 32'd0 : 32'd1);
        tick();
`ifndef ID_EX_FORWARDING_EN
        // Producer now in WB; the second bubble lets the capture bypass pick it up.
        bus.mem_regwrite = 0;
        bus.wb_rd = 5'd7; bus.wb_regwrite = 1; bus.wb_result = 32'hCAFE;
        #1;
        chk("lu_bubble2_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_stall_c3", 32'(bus.stall), 32'd0);
        tick();
        bus.wb_regwrite = 0;
        #1;
`else
        bus.mem_regwrite = 0;
        bus.wb_rd = 5'd7; bus.wb_regwrite = 1; bus.wb_result = 32'hCAFE;
        #1;
`endif
        chk("lu_op2", bus.alu_op2, 32'hCAFE);
        chk("lu_op1", bus.alu_op1, 32'h11);
        chk("lu_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_rd", 32'(bus.ex_rd), 32'd8);
        chk("lu_stall_done", 32'(bus.stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
